// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/ALU/memory signal bundle between the multicycle controller and its datapath
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       BrEq;
  logic       BrLT;
  logic       memReady;
  logic       memReq;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       illegalInstr;

  modport master (
    input  op, funct3, funct7b5, BrEq, BrLT, memReady,
    output memReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegalInstr
  );

  modport slave (
    output op, funct3, funct7b5, BrEq, BrLT, memReady,
    input  memReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegalInstr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V control FSM driving ALU selects and a shared memory handshake
module multicycle_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  state_t     state;
  logic [2:0] exec_op;
  logic       exec_ok;
  logic       take;
  logic       br_ok;

  // funct7b5 only selects sub on register ops; shifts honour it in both forms
  always_comb begin
    exec_op = ALU_ADD;
    exec_ok = 1'b1;
    case (bus.funct3)
      3'b000:  exec_op = (state == EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  exec_op = ALU_AND;
      3'b110:  exec_op = ALU_OR;
      3'b010:  exec_op = ALU_SLT;
      3'b001:  exec_op = ALU_SLL;
      3'b101:  exec_op = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      default: exec_ok = 1'b0;
    endcase
  end

  always_comb begin
    take  = 1'b0;
    br_ok = 1'b1;
    case (bus.funct3)
      3'b000:  take = bus.BrEq;
      3'b001:  take = !bus.BrEq;
      3'b100:  take = bus.BrLT;
      3'b101:  take = !bus.BrLT;
      default: br_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= FETCH;
      bus.illegalInstr <= 1'b0;
    end else begin
      case (state)
        FETCH:    if (bus.memReady) state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BR:        state <= BRANCH;
            OP_JAL:       state <= JAL;
            default:      state <= TRAP;
          endcase
        end
        MEMADR:   state <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (bus.memReady) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (bus.memReady) state <= FETCH;
        EXECR,
        EXECI:    state <= exec_ok ? ALUWB : TRAP;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= br_ok ? FETCH : TRAP;
        JAL:      state <= ALUWB;
        TRAP: begin
          state            <= TRAP;
          bus.illegalInstr <= 1'b1;
        end
        default:  state <= TRAP;
      endcase
    end
  end

  // Gated by rst_n so the datapath sees no request or strobe while reset is held
  always_comb begin
    bus.memReq     = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.memReq    = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.memReady;
          bus.PCWrite   = bus.memReady;
        end
        DECODE: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b01;
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          bus.memReq = 1'b1;
          bus.AdrSrc = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          bus.memReq   = 1'b1;
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
        end
        EXECR: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = exec_op;
        end
        EXECI: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUSrcB    = 2'b01;
          bus.ALUControl = exec_op;
        end
        ALUWB:    bus.RegWrite = 1'b1;
        BRANCH: begin
          bus.ALUSrcA    = 2'b10;
          bus.ALUControl = ALU_SUB;
          bus.PCWrite    = br_ok && take;
        end
        JAL: begin
          bus.ALUSrcA = 2'b01;
          bus.ALUSrcB = 2'b10;
          bus.PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
